// File: rtl/embed_ram_scheduler_pkg.sv
// Shared constants and state encodings for the patch-embed RAM scheduler.
package embed_ram_scheduler_pkg;

    // Word width of the patch-embed RAM this scheduler sequences.
    localparam int unsigned PATCH_EMBED_WIDTH = 64;

    // Default geometry: 4096 words, 2-clock read latency at the embed output.
    localparam int unsigned SCHED_ADDR_W   = 12;
    localparam int unsigned SCHED_FILL_CNT = 4096;
    localparam int unsigned SCHED_RD_LAT   = 2;

    typedef enum logic [2:0] {
        SCHED_IDLE     = 3'd0,
        SCHED_FILL     = 3'd1,
        SCHED_DRAIN    = 3'd2,
        SCHED_FLUSH    = 3'd3,
        SCHED_WAIT_MLP = 3'd4,
        SCHED_GRANT    = 3'd5
    } sched_state_e;

endpackage

// File: rtl/embed_rd_valid_pipe.sv
// RD_LAT-deep shift of {valid, last} that tracks reads in flight to the RAM.
// o_empty is high when no valid is held in any stage.
module embed_rd_valid_pipe #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic s_clk,
    input  logic s_rst,
    input  logic i_valid,
    input  logic i_last,
    output logic o_valid,
    output logic o_last,
    output logic o_empty
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] last_q, last_d;

    // Shift one stage per clock; last is only meaningful alongside valid.
    always_comb begin
        vld_d     = '0;
        last_d    = '0;
        vld_d[0]  = i_valid;
        last_d[0] = i_valid & i_last;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    // Pipe registers; reset discards every read in flight.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign o_valid = vld_q[RD_LAT-1];
    assign o_last  = last_q[RD_LAT-1];
    assign o_empty = ~|vld_q;

endmodule

// File: rtl/embed_ram_scheduler.sv
// Patch-embed RAM scheduler: counts the embed fill, drains the stored words to
// a downstream consumer, then hands RAM ownership to the MLP until it is done.
// Define EMBED_SCHED_PERF_EN to add stall and frame counters.
module embed_ram_scheduler
    import embed_ram_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W   = SCHED_ADDR_W,
    parameter int unsigned FILL_CNT = SCHED_FILL_CNT,
    parameter int unsigned RD_LAT   = SCHED_RD_LAT
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              i_start,
    input  logic              i_embed_valid,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ready,
    output logic              o_rd_data_valid,
    output logic              o_rd_last,
    input  logic              i_mlp_req,
    output logic              o_mlp_gnt,
    input  logic              i_mlp_done,
    output logic              o_switch,
    output logic              o_busy,
    output logic [2:0]        o_state,
`ifdef EMBED_SCHED_PERF_EN
    output logic [15:0]       o_stall_cnt,
    output logic [15:0]       o_frame_cnt,
`endif
    output logic              o_err
);

    // One extra bit so FILL_CNT == 2**ADDR_W is representable without aliasing.
    localparam int unsigned      CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FILL_CNT - 1);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             switch_q, switch_d;
    logic             gnt_q, gnt_d;
    logic             err_q, err_d;
    logic             issue, issue_last;
    logic             pipe_empty;

    // Next-state, counter and error logic.
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        err_d      = err_q;
        issue      = 1'b0;
        issue_last = 1'b0;

        case (state_q)
            SCHED_IDLE: begin
                if (i_embed_valid) begin
                    err_d = 1'b1;
                end
                if (i_start) begin
                    state_d  = SCHED_FILL;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                end
            end
            SCHED_FILL: begin
                if (i_embed_valid) begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d = SCHED_DRAIN;
                    end
                end
            end
            SCHED_DRAIN: begin
                if (i_embed_valid) begin
                    err_d = 1'b1;
                end
                if (i_rd_ready) begin
                    issue      = 1'b1;
                    issue_last = (rd_cnt_q == LAST_IDX);
                    rd_cnt_d   = rd_cnt_q + CNT_W'(1);
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d = SCHED_FLUSH;
                    end
                end
            end
            SCHED_FLUSH: begin
                // Hold the switch until the final read data has left the pipe.
                if (pipe_empty) begin
                    state_d = i_mlp_req ? SCHED_GRANT : SCHED_WAIT_MLP;
                end
            end
            SCHED_WAIT_MLP: begin
                if (i_mlp_req) begin
                    state_d = SCHED_GRANT;
                end
            end
            SCHED_GRANT: begin
                // Ownership is held on done only; a dropped request is ignored.
                if (i_mlp_done) begin
                    state_d = SCHED_IDLE;
                end
            end
            default: begin
                state_d = SCHED_IDLE;
            end
        endcase

        if (i_mlp_done && (state_q != SCHED_GRANT)) begin
            err_d = 1'b1;
        end
    end

    // Switch and grant rise the cycle after GRANT entry and fall with the exit.
    always_comb begin
        switch_d = (state_q == SCHED_GRANT) && !i_mlp_done;
        gnt_d    = (state_q == SCHED_GRANT) && !i_mlp_done;
    end

    // State and registered-output flops.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q  <= SCHED_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            switch_q <= 1'b0;
            gnt_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            switch_q <= switch_d;
            gnt_q    <= gnt_d;
            err_q    <= err_d;
        end
    end

    embed_rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_valid_pipe (
        .s_clk   (s_clk),
        .s_rst   (s_rst),
        .i_valid (issue),
        .i_last  (issue_last),
        .o_valid (o_rd_data_valid),
        .o_last  (o_rd_last),
        .o_empty (pipe_empty)
    );

    assign o_rd_addr = rd_cnt_q[ADDR_W-1:0];
    assign o_mlp_gnt = gnt_q;
    assign o_switch  = switch_q;
    assign o_busy    = (state_q != SCHED_IDLE);
    assign o_state   = state_q;
    assign o_err     = err_q;

`ifdef EMBED_SCHED_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Saturating drain-stall count per frame; wrapping completed-frame count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if ((state_q == SCHED_IDLE) && i_start) begin
            stall_cnt_d = '0;
        end else if ((state_q == SCHED_DRAIN) && !i_rd_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if ((state_q == SCHED_GRANT) && i_mlp_done) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Performance counter flops.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            stall_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_embed_ram_scheduler.sv
// Self-checking bench for embed_ram_scheduler: a FILL_CNT=8 instance for the
// protocol scenarios and a default-size (4096) instance for the full-depth run.
module tb_embed_ram_scheduler;

    localparam int N   = 8;
    localparam int NF  = 4096;
    localparam int LAT = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_GRANT = 3'd5;

    logic s_clk = 1'b0;
    logic s_rst = 1'b1;

    // Small instance
    logic        i_start = 0, i_embed_valid = 0, i_rd_ready = 0, i_mlp_req = 0, i_mlp_done = 0;
    logic [11:0] o_rd_addr;
    logic        o_rd_data_valid, o_rd_last, o_mlp_gnt, o_switch, o_busy, o_err;
    logic [2:0]  o_state;

    // Full-depth instance
    logic        f_start = 0, f_embed_valid = 0, f_rd_ready = 0, f_mlp_req = 0, f_mlp_done = 0;
    logic [11:0] f_rd_addr;
    logic        f_rd_data_valid, f_rd_last, f_mlp_gnt, f_switch, f_busy, f_err;
    logic [2:0]  f_state;

`ifdef EMBED_SCHED_PERF_EN
    logic [15:0] o_stall_cnt, o_frame_cnt, f_stall_cnt, f_frame_cnt;
`endif

    embed_ram_scheduler #(.ADDR_W(12), .FILL_CNT(N), .RD_LAT(LAT)) dut (
        .s_clk           (s_clk),
        .s_rst           (s_rst),
        .i_start         (i_start),
        .i_embed_valid   (i_embed_valid),
        .o_rd_addr       (o_rd_addr),
        .i_rd_ready      (i_rd_ready),
        .o_rd_data_valid (o_rd_data_valid),
        .o_rd_last       (o_rd_last),
        .i_mlp_req       (i_mlp_req),
        .o_mlp_gnt       (o_mlp_gnt),
        .i_mlp_done      (i_mlp_done),
        .o_switch        (o_switch),
        .o_busy          (o_busy),
        .o_state         (o_state),
`ifdef EMBED_SCHED_PERF_EN
        .o_stall_cnt     (o_stall_cnt),
        .o_frame_cnt     (o_frame_cnt),
`endif
        .o_err           (o_err)
    );

    embed_ram_scheduler #(.ADDR_W(12), .FILL_CNT(NF), .RD_LAT(LAT)) dut_full (
        .s_clk           (s_clk),
        .s_rst           (s_rst),
        .i_start         (f_start),
        .i_embed_valid   (f_embed_valid),
        .o_rd_addr       (f_rd_addr),
        .i_rd_ready      (f_rd_ready),
        .o_rd_data_valid (f_rd_data_valid),
        .o_rd_last       (f_rd_last),
        .i_mlp_req       (f_mlp_req),
        .o_mlp_gnt       (f_mlp_gnt),
        .i_mlp_done      (f_mlp_done),
        .o_switch        (f_switch),
        .o_busy          (f_busy),
        .o_state         (f_state),
`ifdef EMBED_SCHED_PERF_EN
        .o_stall_cnt     (f_stall_cnt),
        .o_frame_cnt     (f_frame_cnt),
`endif
        .o_err           (f_err)
    );

    always #5 s_clk = ~s_clk;

    int cyc = 0;
    always @(posedge s_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of issued reads: the data valid must appear exactly LAT cycles later.
    typedef struct {
        int addr;
        bit last;
        int due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   n_valid  = 0;
    int   exp_addr = 0;

    always @(negedge s_clk) begin
        if (o_rd_data_valid === 1'b1) begin
            n_valid++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_valid_unexpected: valid at cycle %0d, expected no read in flight",
                         cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.due != cyc || o_rd_last !== mon_e.last) begin
                    n_fail++;
                    $display("FAIL rd_valid_timing: addr %0d got cycle %0d last=%b, expected cycle %0d last=%b",
                             mon_e.addr, cyc, o_rd_last, mon_e.due, mon_e.last);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_valid_missing: addr %0d got no valid, expected one at cycle %0d",
                     sb[0].addr, sb[0].due);
            void'(sb.pop_front());
        end
    end

    // Stimulus: start pulse then N embed writes; returns at the negedge of the last write.
    task automatic start_fill();
        n_valid  = 0;
        exp_addr = 0;
        @(negedge s_clk);
        i_start = 1'b1;
        @(negedge s_clk);
        i_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            i_embed_valid = 1'b1;
            if (k < N - 1) @(negedge s_clk);
        end
    endtask

    // Drain: mode 0 always ready, 1 ready pattern 1,0,0, 2 always ready plus a stray done.
    // Returns at the negedge after the last issue (first FLUSH cycle).
    task automatic drain(input int mode);
        int i;
        bit r;
        i = 0;
        while (exp_addr < N) begin
            @(negedge s_clk);
            i_embed_valid = 1'b0;
            r = (mode == 1) ? (i % 3 == 0) : 1'b1;
            i_mlp_done = (mode == 2 && i == 3);
            i_rd_ready = r;
            n_checks++;
            if (o_state !== ST_DRAIN || o_rd_addr !== 12'(exp_addr)) begin
                n_fail++;
                $display("FAIL drain_addr: state=%0d addr=%0d, expected state=%0d addr=%0d",
                         o_state, o_rd_addr, ST_DRAIN, exp_addr);
            end
            if (r) begin
                sb.push_back('{addr: exp_addr, last: (exp_addr == N - 1), due: cyc + LAT});
                exp_addr++;
            end
            i++;
        end
        @(negedge s_clk);
        i_rd_ready = 1'b0;
        i_mlp_done = 1'b0;
    endtask

    // Ends with a done pulse from GRANT and checks the IDLE return and frame totals.
    task automatic finish_frame(input string name, input bit exp_err);
        i_mlp_done = 1'b1;
        @(negedge s_clk);
        i_mlp_done = 1'b0;
        n_checks++;
        if ({o_state, o_busy, o_switch, o_mlp_gnt, o_err} !== {ST_IDLE, 3'b000, exp_err}) begin
            n_fail++;
            $display("FAIL %s_idle: state/busy/sw/gnt/err=%0d/%b%b%b%b, expected %0d/000%b",
                     name, o_state, o_busy, o_switch, o_mlp_gnt, o_err, ST_IDLE, exp_err);
        end
        n_checks++;
        if (n_valid !== N || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_count: valids=%0d pending=%0d, expected %0d and 0",
                     name, n_valid, sb.size(), N);
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        repeat (2) @(negedge s_clk);
        n_checks++;
        if ({o_rd_addr, o_rd_data_valid, o_rd_last, o_mlp_gnt, o_switch, o_busy, o_state, o_err}
            !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%0d v=%b l=%b g=%b s=%b b=%b st=%0d e=%b, expected all 0",
                     o_rd_addr, o_rd_data_valid, o_rd_last, o_mlp_gnt, o_switch, o_busy,
                     o_state, o_err);
        end
        s_rst = 1'b0;
        @(negedge s_clk);
        n_checks++;
        if ({o_state, o_busy, o_err} !== {ST_IDLE, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_idle: state=%0d busy=%b err=%b, expected 0 0 0",
                     o_state, o_busy, o_err);
        end
    endtask

    task automatic test_nominal();
        i_mlp_req = 1'b1;
        start_fill();
        drain(0);
        n_checks++;
        if ({o_state, o_switch} !== {ST_FLUSH, 1'b0}) begin
            n_fail++;
            $display("FAIL nom_flush: state=%0d sw=%b, expected %0d 0", o_state, o_switch, ST_FLUSH);
        end
        repeat (3) @(negedge s_clk);
        n_checks++;
        if ({o_state, o_busy, o_switch, o_mlp_gnt} !== {ST_GRANT, 3'b100}) begin
            n_fail++;
            $display("FAIL nom_grant_entry: state=%0d b/s/g=%b%b%b, expected %0d 100",
                     o_state, o_busy, o_switch, o_mlp_gnt, ST_GRANT);
        end
        @(negedge s_clk);
        n_checks++;
        if ({o_state, o_switch, o_mlp_gnt} !== {ST_GRANT, 2'b11}) begin
            n_fail++;
            $display("FAIL nom_switch: state=%0d s/g=%b%b, expected %0d 11",
                     o_state, o_switch, o_mlp_gnt, ST_GRANT);
        end
        i_mlp_req = 1'b0;
        repeat (2) @(negedge s_clk);
        n_checks++;
        if ({o_state, o_switch, o_mlp_gnt} !== {ST_GRANT, 2'b11}) begin
            n_fail++;
            $display("FAIL nom_hold_without_req: state=%0d s/g=%b%b, expected %0d 11",
                     o_state, o_switch, o_mlp_gnt, ST_GRANT);
        end
        finish_frame("nom", 1'b0);
    endtask

    task automatic test_backpressure();
        i_mlp_req = 1'b1;
        start_fill();
        drain(1);
        repeat (3) @(negedge s_clk);
        n_checks++;
        if ({o_state, o_switch} !== {ST_GRANT, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_grant: state=%0d sw=%b, expected %0d 0", o_state, o_switch, ST_GRANT);
        end
        @(negedge s_clk);
        finish_frame("bp", 1'b0);
    endtask

    task automatic test_late_mlp();
        i_mlp_req = 1'b0;
        start_fill();
        drain(0);
        repeat (3) @(negedge s_clk);
        n_checks++;
        if ({o_state, o_busy, o_switch, o_mlp_gnt} !== {ST_WAIT, 3'b100}) begin
            n_fail++;
            $display("FAIL late_wait: state=%0d b/s/g=%b%b%b, expected %0d 100",
                     o_state, o_busy, o_switch, o_mlp_gnt, ST_WAIT);
        end
        repeat (4) @(negedge s_clk);
        n_checks++;
        if ({o_state, o_switch} !== {ST_WAIT, 1'b0}) begin
            n_fail++;
            $display("FAIL late_still_wait: state=%0d sw=%b, expected %0d 0",
                     o_state, o_switch, ST_WAIT);
        end
        @(negedge s_clk);
        i_mlp_req = 1'b1;
        @(negedge s_clk);
        n_checks++;
        if ({o_state, o_switch, o_mlp_gnt} !== {ST_GRANT, 2'b00}) begin
            n_fail++;
            $display("FAIL late_grant: state=%0d s/g=%b%b, expected %0d 00",
                     o_state, o_switch, o_mlp_gnt, ST_GRANT);
        end
        @(negedge s_clk);
        n_checks++;
        if ({o_switch, o_mlp_gnt} !== 2'b11) begin
            n_fail++;
            $display("FAIL late_switch: s/g=%b%b, expected 11", o_switch, o_mlp_gnt);
        end
        finish_frame("late", 1'b0);
    endtask

    task automatic test_errors();
        @(negedge s_clk);
        i_embed_valid = 1'b1;
        @(negedge s_clk);
        i_embed_valid = 1'b0;
        n_checks++;
        if ({o_state, o_err} !== {ST_IDLE, 1'b1}) begin
            n_fail++;
            $display("FAIL err_idle_embed: state=%0d err=%b, expected %0d 1", o_state, o_err, ST_IDLE);
        end
        i_mlp_req = 1'b1;
        start_fill();
        n_checks++;
        if ({o_state, o_err} !== {ST_FILL, 1'b1}) begin
            n_fail++;
            $display("FAIL err_sticky_fill: state=%0d err=%b, expected %0d 1", o_state, o_err, ST_FILL);
        end
        drain(2);
        repeat (3) @(negedge s_clk);
        n_checks++;
        if ({o_state, o_err} !== {ST_GRANT, 1'b1}) begin
            n_fail++;
            $display("FAIL err_grant: state=%0d err=%b, expected %0d 1", o_state, o_err, ST_GRANT);
        end
        @(negedge s_clk);
        finish_frame("err", 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        int bad;
        i_mlp_req = 1'b1;
        start_fill();
        for (int k = 0; k < 2; k++) begin
            @(negedge s_clk);
            i_embed_valid = 1'b0;
            i_rd_ready    = 1'b1;
            n_checks++;
            if (o_rd_addr !== 12'(k)) begin
                n_fail++;
                $display("FAIL rst_pre_addr: addr=%0d, expected %0d", o_rd_addr, k);
            end
            sb.push_back('{addr: k, last: 1'b0, due: cyc + LAT});
        end
        @(negedge s_clk);
        i_rd_ready = 1'b0;
        s_rst      = 1'b1;
        @(posedge s_clk);
        sb.delete();
        @(negedge s_clk);
        n_checks++;
        if ({o_rd_addr, o_rd_data_valid, o_rd_last, o_mlp_gnt, o_switch, o_busy, o_state, o_err}
            !== 21'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: addr=%0d v=%b l=%b g=%b s=%b b=%b st=%0d e=%b, expected all 0",
                     o_rd_addr, o_rd_data_valid, o_rd_last, o_mlp_gnt, o_switch, o_busy,
                     o_state, o_err);
        end
        s_rst = 1'b0;
        bad   = 0;
        repeat (6) begin
            @(negedge s_clk);
            if (o_rd_data_valid !== 1'b0 || o_state !== ST_IDLE) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_no_valid_after: %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_full_depth();
        int  issued, seen, budget;
        bit  addr_ok, last_ok, early_last, saw_4095, granted;
        issued = 0; seen = 0; budget = 0;
        addr_ok = 1'b1; last_ok = 1'b0; early_last = 1'b0; saw_4095 = 1'b0; granted = 1'b0;
        f_mlp_req = 1'b1;
        @(negedge s_clk);
        f_start = 1'b1;
        @(negedge s_clk);
        f_start = 1'b0;
        for (int k = 0; k < NF; k++) begin
            f_embed_valid = 1'b1;
            if (k < NF - 1) @(negedge s_clk);
        end
        while (seen < NF && budget < 3 * NF) begin
            @(negedge s_clk);
            budget++;
            f_embed_valid = 1'b0;
            if (f_rd_data_valid === 1'b1) begin
                seen++;
                if (f_rd_last === 1'b1) begin
                    if (seen == NF) last_ok = 1'b1;
                    else early_last = 1'b1;
                end
            end
            if (issued < NF) begin
                if (f_state !== ST_DRAIN || f_rd_addr !== 12'(issued)) addr_ok = 1'b0;
                if (issued == NF - 1 && f_rd_addr === 12'd4095) saw_4095 = 1'b1;
                f_rd_ready = 1'b1;
                issued++;
            end else begin
                f_rd_ready = 1'b0;
            end
        end
        f_rd_ready = 1'b0;
        n_checks++;
        if (!addr_ok || !saw_4095) begin
            n_fail++;
            $display("FAIL full_addr: in_order=%b last_addr_4095=%b, expected 1 1", addr_ok, saw_4095);
        end
        n_checks++;
        if (seen != NF || !last_ok || early_last) begin
            n_fail++;
            $display("FAIL full_last: valids=%0d last_on_final=%b early_last=%b, expected %0d 1 0",
                     seen, last_ok, early_last, NF);
        end
        for (int k = 0; k < 10 && !granted; k++) begin
            @(negedge s_clk);
            if (f_rd_data_valid !== 1'b0) seen++;
            if (f_state === ST_GRANT) granted = 1'b1;
        end
        n_checks++;
        if (!granted || seen != NF) begin
            n_fail++;
            $display("FAIL full_grant: granted=%b valids=%0d, expected 1 %0d", granted, seen, NF);
        end
        @(negedge s_clk);
        f_mlp_done = 1'b1;
        @(negedge s_clk);
        f_mlp_done = 1'b0;
        n_checks++;
        if ({f_state, f_switch, f_mlp_gnt, f_err} !== {ST_IDLE, 3'b000}) begin
            n_fail++;
            $display("FAIL full_idle: state=%0d s/g/e=%b%b%b, expected %0d 000",
                     f_state, f_switch, f_mlp_gnt, f_err, ST_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_late_mlp();
        test_errors();
        test_reset_mid_drain();
        test_full_depth();
        repeat (2) @(negedge s_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
